msg_burst_writer: RTL and testbench

- Downstream stage of the decoder core. Consumes the 4-bit recovered message nibbles (msg_valid / msg_bits) and packs them into 32-bit words.
- Buffers packed words in an internal FIFO and writes them to memory at msg_baddr through AXI4 write bursts on the m00_axi master port.
- Shares the AXI clock domain with the image-read path. Signals completion and write errors to the decoder top level.

---
 rtl/msg_burst_writer.sv | 232 +++++++++++++++++++++++
 tb/tb_msg_burst_writer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_burst_writer.sv
// msg_burst_writer: packs message nibbles into 32-bit words
// and writes them to memory as AXI4 INCR write bursts.
module msg_burst_writer #(
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  axi_clk,
  input  logic                  axi_resetn,
  input  logic                  begin_writing,
  input  logic [ADDR_WIDTH-1:0] msg_baddr,
  input  logic                  msg_valid,
  input  logic [3:0]            msg_bits,
  input  logic                  msg_last,
  output logic                  msg_ready,
  output logic [ADDR_WIDTH-1:0] m00_axi_awaddr,
  output logic [7:0]            m00_axi_awlen,
  output logic [2:0]            m00_axi_awsize,
  output logic [1:0]            m00_axi_awburst,
  output logic                  m00_axi_awvalid,
  input  logic                  m00_axi_awready,
  output logic [31:0]           m00_axi_wdata,
  output logic [3:0]            m00_axi_wstrb,
  output logic                  m00_axi_wlast,
  output logic                  m00_axi_wvalid,
  input  logic                  m00_axi_wready,
  input  logic [1:0]            m00_axi_bresp,
  input  logic                  m00_axi_bvalid,
  output logic                  m00_axi_bready,
  output logic [15:0]           words_written,
  output logic                  write_done,
  output logic                  m00_axi_error
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    IDLE,
    AW,
    W,
    B,
    FINISH
  } state_t;

  state_t                state;
  logic                  armed;
  logic                  last_seen;
  logic [2:0]            nib_cnt;
  logic [31:0]           word_q;
  logic [31:0]           push_data;
  logic                  start;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  pack_idle;
  logic [31:0]           mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [8:0]            len_q;
  logic [8:0]            beat_q;
  logic [8:0]            burst_len;
  logic [16:0]           ww_sum;
  logic                  go_burst;
  logic                  go_finish;
  logic                  wvalid_q;
  logic                  unused_bits;

  assign unused_bits = ^msg_baddr[1:0];

  assign m00_axi_awsize  = 3'b010;
  assign m00_axi_awburst = 2'b01;
  assign m00_axi_wstrb   = 4'hF;

  assign start     = begin_writing && !armed;
  assign fifo_full = fifo_count == CW'(FIFO_DEPTH);
  assign msg_ready = armed && !last_seen && !fifo_full;
  assign accept    = msg_valid && msg_ready;
  assign push      = accept && (nib_cnt == 3'd7 || msg_last);
  assign pack_idle = nib_cnt == 3'd0;
  assign pop       = wvalid_q && m00_axi_wready;

  assign m00_axi_wvalid = wvalid_q;
  assign m00_axi_wlast  = wvalid_q && (beat_q == len_q - 9'd1);
  assign m00_axi_wdata  = wvalid_q ? mem[rd_ptr] : '0;

  // word being assembled with the incoming nibble dropped in
  always_comb begin
    push_data = word_q;
    push_data[{nib_cnt, 2'b00} +: 4] = msg_bits;
  end

  // burst length and burst/finish decisions
  always_comb begin
    if (fifo_count >= CW'(BURST_LEN))
      burst_len = 9'(BURST_LEN);
    else
      burst_len = 9'(fifo_count);
    go_burst  = armed &&
                (fifo_count >= CW'(BURST_LEN) ||
                 (last_seen && fifo_count != '0 && pack_idle));
    go_finish = armed && last_seen &&
                fifo_count == '0 && pack_idle;
    ww_sum    = {1'b0, words_written} + 17'(len_q);
  end

  // nibble packer; partial words stay zero above the last nibble
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      word_q    <= '0;
      nib_cnt   <= '0;
      last_seen <= 1'b0;
    end else if (start) begin
      word_q    <= '0;
      nib_cnt   <= '0;
      last_seen <= 1'b0;
    end else if (accept) begin
      if (push) begin
        word_q  <= '0;
        nib_cnt <= '0;
      end else begin
        word_q  <= push_data;
        nib_cnt <= nib_cnt + 3'd1;
      end
      if (msg_last)
        last_seen <= 1'b1;
    end
  end

  // word storage; contents are don't-care until pushed
  always_ff @(posedge axi_clk) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // arming and the AW -> W -> B burst sequencer
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state           <= IDLE;
      armed           <= 1'b0;
      cur_addr        <= '0;
      len_q           <= '0;
      beat_q          <= '0;
      m00_axi_awaddr  <= '0;
      m00_axi_awlen   <= '0;
      m00_axi_awvalid <= 1'b0;
      wvalid_q        <= 1'b0;
      m00_axi_bready  <= 1'b0;
      words_written   <= '0;
      write_done      <= 1'b0;
      m00_axi_error   <= 1'b0;
    end else begin
      write_done <= 1'b0;
      if (start) begin
        armed         <= 1'b1;
        cur_addr      <= {msg_baddr[ADDR_WIDTH-1:2], 2'b00};
        words_written <= '0;
        m00_axi_error <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (go_burst) begin
            len_q           <= burst_len;
            m00_axi_awaddr  <= cur_addr;
            m00_axi_awlen   <= 8'(burst_len - 9'd1);
            m00_axi_awvalid <= 1'b1;
            state           <= AW;
          end else if (go_finish) begin
            state <= FINISH;
          end
        end
        AW: begin
          if (m00_axi_awready) begin
            m00_axi_awvalid <= 1'b0;
            wvalid_q        <= 1'b1;
            beat_q          <= '0;
            state           <= W;
          end
        end
        W: begin
          if (m00_axi_wready) begin
            beat_q <= beat_q + 9'd1;
            if (m00_axi_wlast) begin
              wvalid_q       <= 1'b0;
              m00_axi_bready <= 1'b1;
              state          <= B;
            end
          end
        end
        B: begin
          if (m00_axi_bvalid) begin
            m00_axi_bready <= 1'b0;
            words_written  <= ww_sum[16] ? 16'hFFFF : ww_sum[15:0];
            cur_addr       <= cur_addr + (ADDR_WIDTH'(len_q) << 2);
            if (m00_axi_bresp != 2'b00)
              m00_axi_error <= 1'b1;
            state <= IDLE;
          end
        end
        FINISH: begin
          write_done <= 1'b1;
          armed      <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_burst_writer.sv
// tb_msg_burst_writer: directed table-driven bench with an
// AXI slave model and a word-level FIFO occupancy model.
module tb_msg_burst_writer;

  logic        axi_clk = 1'b0;
  logic        axi_resetn = 1'b0;
  logic        begin_writing = 1'b0;
  logic [31:0] msg_baddr = '0;
  logic        msg_valid = 1'b0;
  logic [3:0]  msg_bits = '0;
  logic        msg_last = 1'b0;
  logic        msg_ready;
  logic [31:0] m00_axi_awaddr;
  logic [7:0]  m00_axi_awlen;
  logic [2:0]  m00_axi_awsize;
  logic [1:0]  m00_axi_awburst;
  logic        m00_axi_awvalid;
  logic        m00_axi_awready = 1'b0;
  logic [31:0] m00_axi_wdata;
  logic [3:0]  m00_axi_wstrb;
  logic        m00_axi_wlast;
  logic        m00_axi_wvalid;
  logic        m00_axi_wready = 1'b0;
  logic [1:0]  m00_axi_bresp = 2'b00;
  logic        m00_axi_bvalid = 1'b0;
  logic        m00_axi_bready;
  logic [15:0] words_written;
  logic        write_done;
  logic        m00_axi_error;

  msg_burst_writer dut (
    .axi_clk         (axi_clk),
    .axi_resetn      (axi_resetn),
    .begin_writing   (begin_writing),
    .msg_baddr       (msg_baddr),
    .msg_valid       (msg_valid),
    .msg_bits        (msg_bits),
    .msg_last        (msg_last),
    .msg_ready       (msg_ready),
    .m00_axi_awaddr  (m00_axi_awaddr),
    .m00_axi_awlen   (m00_axi_awlen),
    .m00_axi_awsize  (m00_axi_awsize),
    .m00_axi_awburst (m00_axi_awburst),
    .m00_axi_awvalid (m00_axi_awvalid),
    .m00_axi_awready (m00_axi_awready),
    .m00_axi_wdata   (m00_axi_wdata),
    .m00_axi_wstrb   (m00_axi_wstrb),
    .m00_axi_wlast   (m00_axi_wlast),
    .m00_axi_wvalid  (m00_axi_wvalid),
    .m00_axi_wready  (m00_axi_wready),
    .m00_axi_bresp   (m00_axi_bresp),
    .m00_axi_bvalid  (m00_axi_bvalid),
    .m00_axi_bready  (m00_axi_bready),
    .words_written   (words_written),
    .write_done      (write_done),
    .m00_axi_error   (m00_axi_error)
  );

  always #5 axi_clk = ~axi_clk;

  int checks = 0;
  int errors = 0;

  // stimulus-side controls
  int clr_seq = 0;
  bit stall = 1'b0;
  bit hold_w = 1'b0;
  bit chk_en = 1'b0;
  bit prearm = 1'b0;
  int err_burst = -1;

  // monitor-side state
  int clr_ack = 0;
  int model_cnt = 0;
  int mon_nib = 0;
  int ready_viol = 0;
  int prearm_bad = 0;
  int prearm_n = 0;
  int done_cnt = 0;
  int b_pend = 0;
  int b_idx = 0;
  int aw_wait = 0;
  int w_wait = 0;
  int beat = 0;
  int w_burst = 0;
  int proto_err = 0;
  bit last_acc = 1'b0;
  logic [31:0] aw_addr_q[$];
  int          aw_len_q[$];
  logic [31:0] wd_q[$];

  typedef struct {
    logic [31:0] base;
    int          n;
    bit          st;
    int          eb;
    int          exp_bursts;
    int          exp_ww;
    bit          exp_err;
  } vec_t;

  // slave model and monitors; all edges driven at negedge
  always @(negedge axi_clk) begin
    if (clr_ack != clr_seq) begin
      clr_ack = clr_seq;
      model_cnt = 0; mon_nib = 0; ready_viol = 0;
      prearm_bad = 0; prearm_n = 0; done_cnt = 0;
      b_pend = 0; b_idx = 0; aw_wait = 0; w_wait = 0;
      beat = 0; w_burst = 0; proto_err = 0; last_acc = 1'b0;
      aw_addr_q.delete(); aw_len_q.delete(); wd_q.delete();
    end
    if (!axi_resetn) begin
      m00_axi_awready = 1'b0;
      m00_axi_wready  = 1'b0;
      m00_axi_bvalid  = 1'b0;
      m00_axi_bresp   = 2'b00;
    end else begin
      if (chk_en && !last_acc &&
          (msg_ready !== (model_cnt != 32)))
        ready_viol++;
      if (prearm) begin
        prearm_n++;
        if (msg_ready !== 1'b0) prearm_bad++;
      end
      if (write_done) done_cnt++;
      m00_axi_bvalid = b_pend > 0;
      m00_axi_bresp = (m00_axi_bvalid && b_idx == err_burst) ?
                      2'b10 : 2'b00;
      if (m00_axi_bvalid && m00_axi_bready) begin
        b_pend--;
        b_idx++;
      end
      if (m00_axi_wvalid && w_burst >= aw_len_q.size())
        proto_err++;
      m00_axi_awready = aw_wait == 0;
      if (aw_wait > 0) aw_wait--;
      if (m00_axi_awvalid && m00_axi_awready) begin
        aw_addr_q.push_back(m00_axi_awaddr);
        aw_len_q.push_back(int'(m00_axi_awlen) + 1);
        aw_wait = stall ? int'($urandom_range(0, 5)) : 0;
      end
      m00_axi_wready = !hold_w && w_wait == 0;
      if (w_wait > 0) w_wait--;
      if (m00_axi_wvalid && m00_axi_wready) begin
        if (w_burst < aw_len_q.size() &&
            m00_axi_wlast !== (beat == aw_len_q[w_burst] - 1))
          proto_err++;
        wd_q.push_back(m00_axi_wdata);
        model_cnt--;
        beat++;
        if (m00_axi_wlast) begin
          beat = 0;
          w_burst++;
          b_pend++;
        end
        w_wait = stall ? int'($urandom_range(0, 5)) : 0;
      end
      if (msg_valid && msg_ready) begin
        mon_nib++;
        if (mon_nib == 8 || msg_last) begin
          model_cnt++;
          mon_nib = 0;
        end
        if (msg_last) last_acc = 1'b1;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int j,
                                           input int n);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 8; k++)
      if (8 * j + k < n)
        w[4*k +: 4] = 4'((8 * j + k) % 16);
    return w;
  endfunction

  task automatic clr_sb();
    clr_seq++;
    @(negedge axi_clk);
    #1;
  endtask

  task automatic pulse_begin(input logic [31:0] a);
    @(posedge axi_clk); #1;
    begin_writing = 1'b1;
    msg_baddr = a;
    @(posedge axi_clk); #1;
    begin_writing = 1'b0;
    msg_baddr = '0;
  endtask

  task automatic send(input int lo, input int hi, input int n);
    bit acc;
    for (int i = lo; i < hi; i++) begin
      msg_valid = 1'b1;
      msg_bits = 4'(i % 16);
      msg_last = (i == n - 1);
      acc = 1'b0;
      for (int c = 0; c < 2000 && !acc; c++) begin
        @(negedge axi_clk);
        if (msg_ready) acc = 1'b1;
        @(posedge axi_clk); #1;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL nib_accept got 0 exp 1 at nibble %0d", i);
        msg_valid = 1'b0;
        msg_last = 1'b0;
        return;
      end
    end
    msg_valid = 1'b0;
    msg_last = 1'b0;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 20000 && done_cnt == 0; c++)
      @(posedge axi_clk);
    chk("done_seen", done_cnt > 0, 1);
    repeat (10) @(posedge axi_clk);
    #1;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_ctl"}, {m00_axi_awvalid, m00_axi_wvalid,
                      m00_axi_wlast, m00_axi_bready, msg_ready,
                      write_done, m00_axi_error}, 0);
    chk({p, "_aw"}, {m00_axi_awaddr, m00_axi_awlen}, 0);
    chk({p, "_wdata"}, m00_axi_wdata, 0);
    chk({p, "_ww"}, words_written, 0);
    chk({p, "_const"},
        {m00_axi_awsize, m00_axi_awburst, m00_axi_wstrb},
        {3'b010, 2'b01, 4'hF});
  endtask

  task automatic run(input logic [31:0] a, input int n,
                     input bit st, input int eb);
    clr_sb();
    stall = st;
    err_burst = eb;
    pulse_begin(a);
    chk("ww_clr", words_written, 0);
    chk("err_clr", m00_axi_error, 0);
    chk_en = 1'b1;
    send(0, n, n);
    wait_done();
    chk_en = 1'b0;
  endtask

  task automatic verify(input string t, input logic [31:0] base,
                        input int n, input int eb, input int eww,
                        input bit eerr);
    int words;
    int bad;
    int el;
    words = (n + 7) / 8;
    chk({t, "_bursts"}, aw_addr_q.size(), eb);
    bad = 0;
    for (int b = 0; b < aw_addr_q.size(); b++) begin
      el = (words - 16 * b > 16) ? 16 : words - 16 * b;
      if (aw_addr_q[b] !== base + 32'(64 * b) ||
          aw_len_q[b] != el)
        bad++;
    end
    chk({t, "_aw_bad"}, bad, 0);
    chk({t, "_nwords"}, wd_q.size(), words);
    bad = 0;
    for (int j = 0; j < wd_q.size(); j++)
      if (wd_q[j] !== exp_word(j, n)) bad++;
    chk({t, "_data_bad"}, bad, 0);
    chk({t, "_ww"}, words_written, eww);
    chk({t, "_err"}, m00_axi_error, eerr);
    chk({t, "_done_cnt"}, done_cnt, 1);
    chk({t, "_proto"}, proto_err, 0);
    chk({t, "_ready"}, ready_viol, 0);
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{32'h400, 128, 1'b0, -1, 1, 16, 1'b0};
    tbl[1] = '{32'h400, 512, 1'b0,  1, 4, 64, 1'b1};
    tbl[2] = '{32'h400,  20, 1'b0, -1, 1,  3, 1'b0};
    tbl[3] = '{32'h400, 512, 1'b1, -1, 4, 64, 1'b0};

    #12;
    chk_reset("reset");
    repeat (2) @(posedge axi_clk);
    #3 axi_resetn = 1'b1;

    for (int v = 0; v < 4; v++) begin
      run(tbl[v].base, tbl[v].n, tbl[v].st, tbl[v].eb);
      verify($sformatf("vec%0d", v), tbl[v].base, tbl[v].n,
             tbl[v].exp_bursts, tbl[v].exp_ww, tbl[v].exp_err);
    end

    // valid before arming, unaligned base, restart ignored
    clr_sb();
    stall = 1'b0;
    err_burst = -1;
    prearm = 1'b1;
    msg_valid = 1'b1;
    msg_bits = 4'h0;
    repeat (6) @(posedge axi_clk);
    #1;
    msg_valid = 1'b0;
    prearm = 1'b0;
    chk("prearm_ready", prearm_bad, 0);
    chk("prearm_samples", prearm_n >= 4, 1);
    pulse_begin(32'h402);
    chk_en = 1'b1;
    send(0, 10, 128);
    pulse_begin(32'h800);
    send(10, 128, 128);
    wait_done();
    chk_en = 1'b0;
    verify("restart", 32'h400, 128, 1, 16, 1'b0);

    // fill the FIFO behind a stuck W channel, then reset mid-W
    clr_sb();
    hold_w = 1'b1;
    pulse_begin(32'h400);
    chk_en = 1'b1;
    send(0, 256, 300);
    repeat (3) @(posedge axi_clk);
    #1;
    chk("full_wvalid", m00_axi_wvalid, 1);
    chk("full_ready", msg_ready, 0);
    chk("full_model", model_cnt, 32);
    chk("full_viol", ready_viol, 0);
    chk("full_wdata", m00_axi_wdata, 32'h76543210);
    chk_en = 1'b0;
    @(negedge axi_clk);
    #2 axi_resetn = 1'b0;
    #1;
    chk_reset("midw");
    repeat (3) @(posedge axi_clk);
    hold_w = 1'b0;
    clr_sb();
    #2 axi_resetn = 1'b1;

    run(32'h400, 128, 1'b0, -1);
    verify("post_rst", 32'h400, 128, 1, 16, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
